// File: rtl/serial_tx.sv
// serial_tx: 8N1 UART transmitter, LSB first, fed from a byte FIFO.
// Frames drain back-to-back with no idle gap while the FIFO holds data.
module serial_tx #(
   parameter int WAIT_DIV   = 434,
   parameter int FIFO_DEPTH = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       Wr_en,
   input  logic [7:0] write_data,
   output logic       Full,
   output logic       Empty,
   output logic       Busy,
   output logic       Overflow,
   output logic       txd
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(WAIT_DIV);

   typedef enum logic [1:0] {
      s_idle,
      s_start,
      s_data,
      s_stop
   } state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            txd_q, txd_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [7:0]      mem_d [FIFO_DEPTH];

   logic            full, empty;
   logic            wr_acc, pop, baud_last;

   assign full      = (count_q == CW'(FIFO_DEPTH));
   assign empty     = (count_q == '0);
   assign baud_last = (baud_q == BW'(WAIT_DIV - 1));
   assign wr_acc    = Wr_en && !full;

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      txd_d    = txd_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q | (Wr_en & full);
      mem_d    = mem_q;
      pop      = 1'b0;

      // txd_d follows the next state so the line changes on the same edge
      unique case (state_q)
         s_idle: begin
            txd_d = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               state_d = s_start;
               baud_d  = '0;
               txd_d   = 1'b0;
            end
         end
         s_start: begin
            if (baud_last) begin
               state_d = s_data;
               baud_d  = '0;
               bit_d   = 3'd0;
               txd_d   = shift_q[0];
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         s_data: begin
            if (baud_last) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == 3'd7) begin
                  state_d = s_stop;
                  txd_d   = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
                  txd_d = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         s_stop: begin
            if (baud_last) begin
               baud_d = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  state_d = s_start;
                  txd_d   = 1'b0;
               end else begin
                  state_d = s_idle;
                  txd_d   = 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
      endcase

      if (pop) begin
         shift_d  = mem_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (wr_acc) begin
         mem_d[wr_ptr_q] = write_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end

      unique case ({wr_acc, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= s_idle;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         txd_q    <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         txd_q    <= txd_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset; occupancy alone decides validity
   always_ff @(posedge CLK) begin
      mem_q <= mem_d;
   end

   assign Full     = full;
   assign Empty    = empty;
   assign Busy     = (state_q != s_idle);
   assign Overflow = ovf_q;
   assign txd      = txd_q;

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- UART transmitter (8N1, LSB first); the send-side counterpart to the boot-loader serial receiver.
- Core-side byte writes go into an internal FIFO, which drains onto txd at one bit per WAIT_DIV clocks.
- Used for program output and host-side status/echo.
- Frames are bit-compatible with the receive path at the same WAIT_DIV.

Parameters:
- WAIT_DIV, 434: clock cycles per serial bit (clock freq / baud). Legal range is >= 2.
- FIFO_DEPTH, 16: byte FIFO entries. Must be a power of two, >= 2.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- Wr_en  input  1  write strobe; enqueues write_data when Full=0.
- write_data  input  8  byte to transmit.
- Full  output  1  FIFO holds FIFO_DEPTH bytes.
- Empty  output  1  FIFO holds 0 bytes.
- Busy  output  1  a frame is on the line (state != s_idle).
- Overflow  output  1  sticky; set by Wr_en while Full.
- txd  output  1  serial line, registered, idle high.

Behaviour:
- Reset (RST=1 at an edge): txd=1, Full=0, Empty=1, Busy=0, Overflow=0. FIFO pointers/count=0, state=s_idle, bit/baud counters=0. Reset mid-frame aborts the frame and discards FIFO contents; txd is 1 the cycle after reset.
- Occupancy: count width is $clog2(FIFO_DEPTH)+1. Full=(count==FIFO_DEPTH), Empty=(count==0), both from registered count.
- Write: accepted iff Wr_en=1 and Full=0 at that edge. Data is stored at wr_ptr, wr_ptr wraps modulo FIFO_DEPTH, count+1.
- Write while Full: the byte is dropped, Overflow<=1, and Overflow holds until RST.
- Pop: occurs on the edge where the serializer leaves s_idle or re-arms from s_stop. Head goes to shift register, rd_ptr wraps, count-1.
- Simultaneous accepted write and pop: count unchanged; both pointers advance.
- Serializer states: s_idle, s_start, s_data, s_stop. baud_cnt counts 0..WAIT_DIV-1; bit_cnt counts 0..7.
- s_idle: txd=1. If Empty=0: pop, baud_cnt<=0, go to s_start.
- s_start: txd=0 for WAIT_DIV cycles. Then go to s_data with bit_cnt=0.
- s_data: txd=shift[0] for WAIT_DIV cycles, then shift right. After bit 7 (bit_cnt==7), go to s_stop.
- s_stop: txd=1 for WAIT_DIV cycles. At the end, if Empty=0 pop and go directly to s_start (no idle gap); else go to s_idle.
- Frame length is exactly 10*WAIT_DIV cycles. Back-to-back frames have zero gap.
- Latency: with the FIFO empty and the serializer idle, a write captured at edge k drives txd=0 from edge k+1. The whole frame then completes at edge k+1+10*WAIT_DIV.
- txd is driven from a flop (glitch-free). It is never X after reset.
- Writes during a frame never disturb the frame in progress.

Test Plan:
- Reset and idle (WAIT_DIV=4, FIFO_DEPTH=4): hold RST 3 cycles, release, idle 50 cycles -> txd=1, Empty=1, Full=0, Busy=0, Overflow=0 throughout.
- Single byte 0xA5 -> txd=0 from next edge for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles. Busy high for 40 cycles; Empty=1 one cycle after the write.
- Back-to-back 0x55,0x0F written on consecutive cycles -> two frames, 80 cycles total. The second start bit begins on the cycle right after the first stop bit's 4th cycle.
- Fill and overflow: write 6 bytes 0x01..0x06 on consecutive cycles while the first is transmitting. Full=1 after the 5th write (1 popped, 4 queued); 0x06 is dropped and Overflow=1. Line carries 0x01..0x05 only; Overflow stays 1.
- Pointer wrap: write 10 bytes 0x10..0x19 spaced 40 cycles apart -> every byte emitted in order, correct. Full never asserts; pointers wrap twice.
- Reset mid-frame: assert RST during data bit 3 of 0xFF with 2 bytes queued -> txd=1 next cycle, Empty=1, Busy=0. No further frames appear.
